regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we3/ad3/wd3) between two writeback sources: the ALU and the load/store unit (LSU).
- LSU has priority, with an anti-starvation override. ALU results wait in a small FIFO.
- Provides a combinational read-hazard flag so decode can stall when a source register has a write still pending.
- Sits between execute/memory stages and register_file.

Parameters:
ADDRESS_WIDTH, 5, register index width
DATA_WIDTH, 32, register data width
FIFO_DEPTH, 2, ALU pending-write FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive LSU grants with FIFO non-empty before ALU is forced

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle when high with alu_valid
alu_rd  input  ADDRESS_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
lsu_valid  input  1  LSU writeback request
lsu_ready  output  1  LSU request accepted when high with lsu_valid
lsu_rd  input  ADDRESS_WIDTH  LSU destination register
lsu_data  input  DATA_WIDTH  load data
rs1  input  ADDRESS_WIDTH  decode source 1
rs2  input  ADDRESS_WIDTH  decode source 2
hazard  output  1  rs1/rs2 has a pending write
we3  output  1  register file write enable (registered)
ad3  output  ADDRESS_WIDTH  register file write address (registered)
wd3  output  DATA_WIDTH  register file write data (registered)
fifo_count  output  $clog2(FIFO_DEPTH)+1  ALU FIFO occupancy

Behaviour:
Reset
- Asynchronous on rst_n low.
- we3=0, ad3=0, wd3=0. FIFO empty, fifo_count=0. Starvation counter=0, force flag=0.
- alu_ready=1, lsu_ready=1, hazard=0.
- Reset mid-operation discards all FIFO entries and any pending write. No we3 pulse occurs after reset.

ALU path
- alu_ready = (fifo_count != FIFO_DEPTH).
- alu_ready does not depend on a same-cycle pop; a full FIFO refuses the request even if it pops that cycle.
- Handshake alu_valid && alu_ready && alu_rd!=0 pushes {alu_rd, alu_data} at the edge.
- alu_rd==0: handshake completes, nothing is pushed, no write is ever issued.

LSU path
- lsu_ready = !force.
- Handshake with lsu_rd!=0 counts as an LSU grant.
- lsu_rd==0: accepted and discarded; not treated as a request for arbitration.

Arbitration (per cycle, decided combinationally, registered into we3/ad3/wd3 at the edge)
- force=1 and FIFO non-empty: pop FIFO head and issue it; LSU is stalled (lsu_ready=0).
- Otherwise, LSU handshake with rd!=0: issue the LSU write.
- Otherwise, FIFO non-empty: pop the head and issue it.
- Otherwise: we3=0 next cycle. ad3/wd3 hold their previous values.
- Issue means: at the edge, we3<=1, ad3<=rd, wd3<=data. we3 is high for exactly one cycle per issued write.

Latency
- LSU: we3 high in the cycle after the handshake edge.
- ALU: push at edge N, earliest pop decision in cycle N+1, we3 high after edge N+1 (2 cycles minimum). No bypass around the FIFO.
- Simultaneous push and pop: both occur, count unchanged.
- FIFO order is strict FIFO; pointers wrap modulo FIFO_DEPTH.

Starvation
- starve_cnt increments on each cycle where an LSU write is issued while the FIFO is non-empty.
- starve_cnt clears when a FIFO entry is issued, or when the FIFO is empty.
- When starve_cnt reaches STARVE_LIMIT, force<=1 at the next edge.
- force clears, and starve_cnt clears, at the edge that issues the forced FIFO pop.

Hazard (combinational)
- hazard = 1 if (rs1!=0 and rs1 matches X) or (rs2!=0 and rs2 matches X), where X is any valid FIFO entry's rd, or ad3 while we3=1.
- Matches against requests in their handshake cycle are not counted.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 FIFO entries -> we3=0, fifo_count=0, alu_ready=1 immediately; after release, no spurious we3 pulse.
- Lone ALU write alu_rd=5, alu_data=0xDEADBEEF at edge 0 -> we3=1, ad3=5, wd3=0xDEADBEEF after edge 1; we3=0 after edge 2.
- Collision: ALU rd=3 and LSU rd=7 valid in the same cycle -> LSU write (ad3=7) first, ALU write (ad3=3) next cycle; fifo_count 1 then 0.
- Full FIFO: LSU valid every cycle, ALU pushes rd=1,2 -> fifo_count=2, alu_ready=0 for a third ALU request.
- Starvation: with the FIFO held at 2 entries, after 4 consecutive LSU issues -> one cycle with lsu_ready=0 and FIFO head (rd=1) issued; LSU service resumes the following cycle.
- x0 and hazard: alu_rd=0 -> accepted, fifo_count stays 0, no we3. FIFO holding rd=9 with rs1=9 -> hazard=1; with rs1=0, rs2=4 -> hazard=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between LSU and ALU writeback. ALU results
// wait in a small FIFO; decode gets a combinational hazard flag for pending writes.
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [ADDRESS_WIDTH-1:0]      lsu_rd,
    input  logic [DATA_WIDTH-1:0]         lsu_data,
    input  logic [ADDRESS_WIDTH-1:0]      rs1,
    input  logic [ADDRESS_WIDTH-1:0]      rs2,
    output logic                          hazard,
    output logic                          we3,
    output logic [ADDRESS_WIDTH-1:0]      ad3,
    output logic [DATA_WIDTH-1:0]         wd3,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]         FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]         CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [SC_W-1:0]          STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0]          SC_ZERO    = {SC_W{1'b0}};
    localparam logic [ADDRESS_WIDTH-1:0] REG_ZERO   = {ADDRESS_WIDTH{1'b0}};

    logic [ADDRESS_WIDTH-1:0] mem_rd_r   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [CNT_W-1:0]         count_r;
    logic [SC_W-1:0]          starve_cnt_r;
    logic                     force_r;
    logic                     we3_r;
    logic [ADDRESS_WIDTH-1:0] ad3_r;
    logic [DATA_WIDTH-1:0]    wd3_r;

    logic                     alu_ready_s;
    logic                     lsu_ready_s;
    logic                     fifo_ne_s;
    logic                     push_s;
    logic                     lsu_grant_s;
    logic                     pop_s;
    logic                     issue_s;
    logic [ADDRESS_WIDTH-1:0] issue_rd_s;
    logic [DATA_WIDTH-1:0]    issue_data_s;
    logic [CNT_W-1:0]         count_nxt_s;
    logic [SC_W-1:0]          starve_nxt_s;
    logic                     force_nxt_s;
    logic [FIFO_DEPTH-1:0]    slot_valid_s;
    logic                     hazard_s;

    // x0 is hard-wired, so neither a pending write to it nor a read of it is a hazard
    function automatic logic src_hit(input logic [ADDRESS_WIDTH-1:0] rs,
                                     input logic [ADDRESS_WIDTH-1:0] rd);
        return (rs != REG_ZERO) && (rs == rd);
    endfunction

    assign alu_ready  = alu_ready_s;
    assign lsu_ready  = lsu_ready_s;
    assign hazard     = hazard_s;
    assign we3        = we3_r;
    assign ad3        = ad3_r;
    assign wd3        = wd3_r;
    assign fifo_count = count_r;

    // Handshakes and write-port arbitration: a forced or uncontested FIFO head wins, else the LSU
    always_comb begin
        alu_ready_s  = (count_r != FULL_CNT);
        lsu_ready_s  = ~force_r;
        fifo_ne_s    = (count_r != CNT_ZERO);
        push_s       = alu_valid && alu_ready_s && (alu_rd != REG_ZERO);
        lsu_grant_s  = lsu_valid && lsu_ready_s && (lsu_rd != REG_ZERO);
        pop_s        = 1'b0;
        issue_s      = 1'b0;
        issue_rd_s   = ad3_r;
        issue_data_s = wd3_r;
        if (fifo_ne_s && (force_r || !lsu_grant_s)) begin
            pop_s        = 1'b1;
            issue_s      = 1'b1;
            issue_rd_s   = mem_rd_r[rd_ptr_r];
            issue_data_s = mem_data_r[rd_ptr_r];
        end else if (lsu_grant_s) begin
            issue_s      = 1'b1;
            issue_rd_s   = lsu_rd;
            issue_data_s = lsu_data;
        end else begin
            issue_s      = 1'b0;
        end
    end

    // Occupancy, starvation counter and force-flag next state
    always_comb begin
        count_nxt_s  = count_r;
        starve_nxt_s = starve_cnt_r;
        force_nxt_s  = force_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        if (!fifo_ne_s || pop_s) begin
            starve_nxt_s = SC_ZERO;
            force_nxt_s  = 1'b0;
        end else if (lsu_grant_s) begin
            starve_nxt_s = (starve_cnt_r >= STARVE_MAX) ? STARVE_MAX : starve_cnt_r + SC_W'(1);
            force_nxt_s  = (starve_nxt_s >= STARVE_MAX);
        end else begin
            starve_nxt_s = starve_cnt_r;
            force_nxt_s  = force_r;
        end
    end

    // Which FIFO slots hold live entries, by distance from the read pointer
    always_comb begin
        slot_valid_s = {FIFO_DEPTH{1'b0}};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_valid_s[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_r)} < count_r);
        end
    end

    // Read-hazard flag against every queued write and the write currently on the port
    always_comb begin
        hazard_s = we3_r && (src_hit(rs1, ad3_r) || src_hit(rs2, ad3_r));
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            hazard_s = hazard_s | (slot_valid_s[i] &&
                       (src_hit(rs1, mem_rd_r[i]) || src_hit(rs2, mem_rd_r[i])));
        end
    end

    // ALU pending-write FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_rd_r[i]   <= REG_ZERO;
                mem_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_rd_r[wr_ptr_r]   <= alu_rd;
                mem_data_r[wr_ptr_r] <= alu_data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r             <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // Starvation tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= SC_ZERO;
            force_r      <= 1'b0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
            force_r      <= force_nxt_s;
        end
    end

    // Registered write port; address and data hold when nothing is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_r <= 1'b0;
            ad3_r <= REG_ZERO;
            wd3_r <= {DATA_WIDTH{1'b0}};
        end else begin
            we3_r <= issue_s;
            ad3_r <= issue_rd_s;
            wd3_r <= issue_data_s;
        end
    end

endmodule
